frame_filter_sequencer: RTL and testbench
=========================================

# frame_filter_sequencer

Hardware replacement for the hand-timed control sequencing of the noise-estimation and Wiener passes. The sequencer watches the frame-in-memory indication and the read-burst `rlast`. It then drives the noise-estimation enables block by block and row by row, waits for the noise estimate, and drives the Wiener stats/calc enables, including the pipeline-drain blocks. It sits beside the stream-to-memory/noise-estimation/Wiener top and owns every control input of that top that is currently driven by the testbench.

## Interface
- BLOCK_SIZE, 8: rows per block; also beats per read burst.
- SETTLE_CYCLES, 4: idle cycles before each pass starts (min 1).
- ROW_GAP_CYCLES, 4: enables-low cycles between rows (min 1).
- WIENER_ROW_CYCLES, 8: enables-high cycles per Wiener row.
- DRAIN_BLOCKS, 2: extra Wiener block slots without a start pulse, used for pipeline flush.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits a new frame; sampled only in IDLE.
- blocks_per_frame  in  32  captured on leaving IDLE.
- frame_ready_for_noise_est  in  1  frame stored in memory (pulse or level).
- rlast  in  1  last beat of a noise-estimation read burst.
- estimated_noise_ready  in  1  noise estimate valid.
- noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation  out  1  noise-estimation controls.
- wiener_block_stats_en, wiener_calc_en, start_data_wiener, start_of_frame_wiener  out  1  Wiener controls.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the Wiener pass completes.
- block_idx  out  32  current block in the active pass.
- row_idx  out  $clog2(BLOCK_SIZE)  current row in the block.

## Operation
- Outputs are registered. Reset value of every output is 0, and the state after reset is IDLE.
- IDLE → NE_SETTLE when `enable & frame_ready_for_noise_est & (blocks_per_frame != 0)`. On this transition the block captures `blocks_per_frame` into `nblk` and clears block_idx, row_idx and the `noise_seen` flag. If `blocks_per_frame` is 0, `frame_ready_for_noise_est` is ignored.
- NE_SETTLE: lasts SETTLE_CYCLES cycles with all outputs 0, then → NE_START.
- NE_START (1 cycle): start_data_noise_est=1 and start_of_frame_noise_estimation=(block_idx==0); noise_estimation_en=0. Next state is NE_ROW with row_idx=0.
- NE_ROW: noise_estimation_en=1 until a cycle with rlast=1.
  - If row_idx < BLOCK_SIZE-1: → NE_GAP.
  - If row_idx is the last row: → NE_TAIL.
- NE_GAP: lasts ROW_GAP_CYCLES cycles with en=0, then row_idx+1 and → NE_ROW.
- NE_TAIL: lasts 2 cycles with en=1 (mean-calculation cycle). Then block_idx+1; → NE_START, or → NE_WAIT if block_idx was nblk-1.
- rlast is ignored outside NE_ROW; it is not counted or queued.
- NE_WAIT: en=0. → WN_SETTLE when `estimated_noise_ready | noise_seen`.
  - `noise_seen` is a sticky flag, set by estimated_noise_ready in any non-IDLE state and cleared on leaving IDLE.
  - WN_SETTLE lasts SETTLE_CYCLES cycles, clears block_idx, then → WN_START.
- WN_START (1 cycle):
  - stats_en=calc_en=1.
  - start_data_wiener=(block_idx < nblk).
  - start_of_frame_wiener=(block_idx==0).
  - Next state is WN_ROW with row_idx=0.
- WN_ROW: stats_en=calc_en=1 for WIENER_ROW_CYCLES cycles.
  - If row_idx is not the last row: → WN_GAP.
  - If row_idx is the last row: block_idx+1; → WN_START, or → DONE if block_idx was nblk+DRAIN_BLOCKS-1.
- WN_GAP: stats_en=calc_en=0 for ROW_GAP_CYCLES cycles, then row_idx+1 and → WN_ROW.
- DONE (1 cycle): frame_done=1, all enables 0, then → IDLE.
- Counters:
  - block_idx is 32 bits and is compared against nblk+DRAIN_BLOCKS computed in 33 bits, so there is no wrap.
  - The cycle counter is 16 bits.
- frame_ready_for_noise_est while busy is dropped; there is no queueing.
- The Wiener pass is never preempted; enable affects only IDLE.
- Reset mid-operation: all outputs go to 0 immediately (asynchronous), state → IDLE, and the captured nblk is discarded.

## Timing
- Start latency: frame_ready_for_noise_est asserted at cycle 0 gives the NE_START pulse at cycle 1+SETTLE_CYCLES.
- Noise block duration is 1 + Σrow(cycles until rlast) + (BLOCK_SIZE-1)·ROW_GAP_CYCLES + 2.
- An rlast in the first NE_ROW cycle is accepted, so the minimum row length is 1 cycle.
- Wiener block duration is 1 + BLOCK_SIZE·WIENER_ROW_CYCLES + (BLOCK_SIZE-1)·ROW_GAP_CYCLES. With the defaults this is 93 cycles.
- Noise-ready latency: estimated_noise_ready seen in NE_WAIT at cycle t gives the first WN_START at cycle t+1+SETTLE_CYCLES.
- start_* pulses are exactly 1 cycle. start_of_frame_* is asserted only together with its start_data_* pulse, or with the drain slot for block_idx=0, which cannot occur because nblk ≥ 1.
- frame_done is asserted the cycle after the final WN_ROW cycle.

## Test plan
- **Reset:** assert rst_n=0 mid-WN_ROW → all outputs 0 within the same cycle, busy=0. After release, nothing happens until a new frame_ready_for_noise_est.
- **Noise pass:** blocks_per_frame=2, rlast driven 9 cycles after each noise_estimation_en rise → exactly 2 start_data_noise_est pulses, 1 start_of_frame_noise_estimation (the first), and 16 en-high row windows each ending 2 cycles after the last row's rlast. NE_WAIT is reached.
- **Wiener pass:** blocks_per_frame=2, estimated_noise_ready given in NE_WAIT →
  - 4 WN_START slots of 93 cycles each (372 cycles total).
  - start_data_wiener pulses=2 and start_of_frame_wiener=1.
  - frame_done is asserted 1 cycle after the pass ends.
- **Early noise ready:** estimated_noise_ready pulsed during block 0 of the noise pass → noise_seen is set and NE_WAIT exits on its first cycle.
- **Ignored inputs:** blocks_per_frame=0 with frame_ready_for_noise_est=1 → stays IDLE. enable=0 → stays IDLE. frame_ready_for_noise_est pulsed during the Wiener pass → no second frame.
- **Spurious rlast:** rlast asserted during NE_GAP and NE_START → row_idx and block_idx are unchanged and the row count stays at 8 per block.

Source files
------------

// File: rtl/frame_filter_sequencer.sv
// frame_filter_sequencer: control sequencer for the noise-estimation pass
// followed by the Wiener stats/calc pass, including pipeline-drain blocks.
// All outputs are registered and are decoded from the next-state values.
module frame_filter_sequencer #(
  parameter int unsigned BLOCK_SIZE        = 8,
  parameter int unsigned SETTLE_CYCLES     = 4,
  parameter int unsigned ROW_GAP_CYCLES    = 4,
  parameter int unsigned WIENER_ROW_CYCLES = 8,
  parameter int unsigned DRAIN_BLOCKS      = 2,
  localparam int unsigned ROW_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      blocks_per_frame,
  input  logic             frame_ready_for_noise_est,
  input  logic             rlast,
  input  logic             estimated_noise_ready,
  output logic             noise_estimation_en,
  output logic             start_data_noise_est,
  output logic             start_of_frame_noise_estimation,
  output logic             wiener_block_stats_en,
  output logic             wiener_calc_en,
  output logic             start_data_wiener,
  output logic             start_of_frame_wiener,
  output logic             busy,
  output logic             frame_done,
  output logic [31:0]      block_idx,
  output logic [ROW_W-1:0] row_idx
);

  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      GAP_LAST    = 16'(ROW_GAP_CYCLES - 1);
  localparam logic [15:0]      WROW_LAST   = 16'(WIENER_ROW_CYCLES - 1);
  localparam logic [15:0]      TAIL_LAST   = 16'd1;
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(BLOCK_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_NE_SETTLE, S_NE_START, S_NE_ROW, S_NE_GAP, S_NE_TAIL, S_NE_WAIT,
    S_WN_SETTLE, S_WN_START, S_WN_ROW, S_WN_GAP, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      nblk_q, nblk_d;
  logic [31:0]      blk_q, blk_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             ne_en_q, ne_en_d, ne_start_q, ne_start_d, ne_sof_q, ne_sof_d;
  logic             wn_en_q, wn_en_d, wn_start_q, wn_start_d, wn_sof_q, wn_sof_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             last_ne_blk, last_wn_blk;

  // 33-bit block comparisons so nblk + DRAIN_BLOCKS never wraps
  assign last_ne_blk = ({1'b0, blk_q} + 33'd1) == {1'b0, nblk_q};
  assign last_wn_blk = ({1'b0, blk_q} + 33'd1) == ({1'b0, nblk_q} + 33'(DRAIN_BLOCKS));

  // Next-state, counters, and next-output decode
  always_comb begin
    state_d = state_q;
    nblk_d  = nblk_q;
    blk_d   = blk_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q | (estimated_noise_ready & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (enable && frame_ready_for_noise_est && (blocks_per_frame != '0)) begin
          state_d = S_NE_SETTLE;
          nblk_d  = blocks_per_frame;
          blk_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end
      end
      S_NE_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_NE_START;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_NE_START: begin
        state_d = S_NE_ROW;
        row_d   = '0;
        cnt_d   = '0;
      end
      S_NE_ROW: begin
        if (rlast) begin
          cnt_d   = '0;
          state_d = (row_q == ROW_LAST) ? S_NE_TAIL : S_NE_GAP;
        end
      end
      S_NE_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_NE_ROW;
          row_d   = row_q + ROW_W'(1);
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_NE_TAIL: begin
        if (cnt_q == TAIL_LAST) begin
          state_d = last_ne_blk ? S_NE_WAIT : S_NE_START;
          blk_d   = blk_q + 32'd1;
          row_d   = '0;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_NE_WAIT: begin
        if (estimated_noise_ready || seen_q) begin
          state_d = S_WN_SETTLE;
          blk_d   = '0;
          cnt_d   = '0;
        end
      end
      S_WN_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_WN_START;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_WN_START: begin
        state_d = S_WN_ROW;
        row_d   = '0;
        cnt_d   = '0;
      end
      S_WN_ROW: begin
        if (cnt_q == WROW_LAST) begin
          cnt_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = last_wn_blk ? S_DONE : S_WN_START;
            blk_d   = blk_q + 32'd1;
            row_d   = '0;
          end else state_d = S_WN_GAP;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_WN_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_WN_ROW;
          row_d   = row_q + ROW_W'(1);
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it once registered
    ne_en_d    = (state_d == S_NE_ROW) || (state_d == S_NE_TAIL);
    ne_start_d = (state_d == S_NE_START);
    ne_sof_d   = (state_d == S_NE_START) && (blk_d == '0);
    wn_en_d    = (state_d == S_WN_START) || (state_d == S_WN_ROW);
    wn_start_d = (state_d == S_WN_START) && (blk_d < nblk_d);
    wn_sof_d   = (state_d == S_WN_START) && (blk_d == '0);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nblk_q     <= '0;
      blk_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      ne_en_q    <= 1'b0;
      ne_start_q <= 1'b0;
      ne_sof_q   <= 1'b0;
      wn_en_q    <= 1'b0;
      wn_start_q <= 1'b0;
      wn_sof_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      blk_q      <= blk_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      ne_en_q    <= ne_en_d;
      ne_start_q <= ne_start_d;
      ne_sof_q   <= ne_sof_d;
      wn_en_q    <= wn_en_d;
      wn_start_q <= wn_start_d;
      wn_sof_q   <= wn_sof_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign noise_estimation_en             = ne_en_q;
  assign start_data_noise_est            = ne_start_q;
  assign start_of_frame_noise_estimation = ne_sof_q;
  assign wiener_block_stats_en           = wn_en_q;
  assign wiener_calc_en                  = wn_en_q;
  assign start_data_wiener               = wn_start_q;
  assign start_of_frame_wiener           = wn_sof_q;
  assign busy                            = busy_q;
  assign frame_done                      = done_q;
  assign block_idx                       = blk_q;
  assign row_idx                         = row_q;

endmodule

// File: tb/tb_frame_filter_sequencer.sv
// Scoreboard bench for frame_filter_sequencer: stimulus pushes timed expected
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_frame_filter_sequencer;

  localparam int EV_NES  = 0;
  localparam int EV_WNS  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cyc;
    int blk;
    int sd;
    int sof;
    int aux;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] blocks_per_frame = '0;
  logic        frame_ready_for_noise_est = 1'b0;
  logic        rlast = 1'b0;
  logic        estimated_noise_ready = 1'b0;
  logic        noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation;
  logic        wiener_block_stats_en, wiener_calc_en, start_data_wiener, start_of_frame_wiener;
  logic        busy, frame_done;
  logic [31:0] block_idx;
  logic [2:0]  row_idx;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  spur = 1'b0;
  ev_t exp_q[$];

  frame_filter_sequencer #(
    .BLOCK_SIZE(8), .SETTLE_CYCLES(4), .ROW_GAP_CYCLES(4),
    .WIENER_ROW_CYCLES(8), .DRAIN_BLOCKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blocks_per_frame(blocks_per_frame),
    .frame_ready_for_noise_est(frame_ready_for_noise_est), .rlast(rlast),
    .estimated_noise_ready(estimated_noise_ready),
    .noise_estimation_en(noise_estimation_en), .start_data_noise_est(start_data_noise_est),
    .start_of_frame_noise_estimation(start_of_frame_noise_estimation),
    .wiener_block_stats_en(wiener_block_stats_en), .wiener_calc_en(wiener_calc_en),
    .start_data_wiener(start_data_wiener), .start_of_frame_wiener(start_of_frame_wiener),
    .busy(busy), .frame_done(frame_done), .block_idx(block_idx), .row_idx(row_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input int blk, input int sd,
                      input int sof, input int aux);
    ev_t e;
    e.kind = kind; e.cyc = c; e.blk = blk; e.sd = sd; e.sof = sof; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse frame_ready for one cycle; returns the cycle of the expected NE_START
  task automatic issue_frame(input int nblk, output int s);
    @(negedge clk);
    blocks_per_frame = nblk;
    frame_ready_for_noise_est = 1'b1;
    s = cyc + 5;
    @(negedge clk);
    frame_ready_for_noise_est = 1'b0;
  endtask

  task automatic pulse_noise_ready(input int c);
    wait_until(c);
    estimated_noise_ready = 1'b1;
    @(negedge clk);
    estimated_noise_ready = 1'b0;
  endtask

  // Monitor: detect start pulses, Wiener slot starts and frame_done
  int  ne_rises = 0;
  bit  prev_ne = 1'b0, prev_wen = 1'b0;
  int  prev_blk = 0;

  task automatic observe(input int kind, input int blk, input int sd, input int sof,
                         input int aux);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d at cyc=%0d blk=%0d", kind, cyc, blk);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.blk != blk || e.sd != sd ||
        e.sof != sof || e.aux != aux) begin
      bad++;
      $display("FAIL event actual kind=%0d cyc=%0d blk=%0d sd=%0d sof=%0d aux=%0d required kind=%0d cyc=%0d blk=%0d sd=%0d sof=%0d aux=%0d",
               kind, cyc, blk, sd, sof, aux, e.kind, e.cyc, e.blk, e.sd, e.sof, e.aux);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ne_rises = 0; prev_ne = 1'b0; prev_wen = 1'b0; prev_blk = 0;
      end else begin
        if (noise_estimation_en && !prev_ne) ne_rises++;
        if (start_data_noise_est)
          observe(EV_NES, block_idx, 1, start_of_frame_noise_estimation, noise_estimation_en);
        if (wiener_block_stats_en && row_idx == 3'd0 &&
            (!prev_wen || int'(block_idx) != prev_blk))
          observe(EV_WNS, block_idx, start_data_wiener, start_of_frame_wiener, wiener_calc_en);
        if (frame_done) begin
          observe(EV_DONE, 0, 0, 0, ne_rises);
          ne_rises = 0;
        end
        prev_ne  = noise_estimation_en;
        prev_wen = wiener_block_stats_en;
        prev_blk = block_idx;
      end
    end
  end

  // rlast responder: last beat 9 cycles after each enable rise, optional spurious beats
  initial begin
    int  rcnt;
    bit  pne;
    rcnt = -1; pne = 1'b0;
    forever begin
      @(negedge clk);
      rlast = 1'b0;
      if (!rst_n) begin
        rcnt = -1; pne = 1'b0;
      end else begin
        if (noise_estimation_en && !pne) rcnt = 0;
        else if (rcnt >= 0) rcnt++;
        if (rcnt == 9) begin
          rlast = 1'b1;
          rcnt = -1;
        end
        if (spur && (start_data_noise_est || (!noise_estimation_en && pne))) rlast = 1'b1;
        pne = noise_estimation_en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation,
         wiener_block_stats_en, wiener_calc_en, start_data_wiener, start_of_frame_wiener,
         busy, frame_done, block_idx, row_idx}, 64'd0);
    rst_n = 1'b1;

    // Ignored inputs: zero block count, then enable low
    @(negedge clk);
    enable = 1'b1; blocks_per_frame = 0; frame_ready_for_noise_est = 1'b1;
    repeat (6) begin @(negedge clk); chk("idle_zero_blocks_busy", busy, 0); end
    enable = 1'b0; blocks_per_frame = 2;
    repeat (6) begin @(negedge clk); chk("idle_enable_low_busy", busy, 0); end
    frame_ready_for_noise_est = 1'b0;
    enable = 1'b1;

    // Main frame: 2 blocks, spurious rlast, noise ready inside NE_WAIT,
    // extra frame_ready during the Wiener pass
    spur = 1'b1;
    issue_frame(2, s);
    push(EV_NES, s, 0, 1, 1, 0);
    push(EV_NES, s + 111, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      push(EV_WNS, s + 229 + 93 * k, k, (k < 2) ? 1 : 0, (k == 0) ? 1 : 0, 1);
    push(EV_DONE, s + 601, 0, 0, 0, 16);
    wait_until(s + 223);
    chk("ne_wait_en_low", noise_estimation_en, 0);
    chk("ne_wait_busy", busy, 1);
    pulse_noise_ready(s + 224);
    spur = 1'b0;
    wait_until(s + 300);
    frame_ready_for_noise_est = 1'b1;
    @(negedge clk);
    frame_ready_for_noise_est = 1'b0;
    wait_until(s + 640);
    chk("after_frame_busy", busy, 0);

    // Early noise ready during block 0
    issue_frame(2, s);
    push(EV_NES, s, 0, 1, 1, 0);
    push(EV_NES, s + 111, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++)
      push(EV_WNS, s + 227 + 93 * k, k, (k < 2) ? 1 : 0, (k == 0) ? 1 : 0, 1);
    push(EV_DONE, s + 599, 0, 0, 0, 16);
    pulse_noise_ready(s + 20);
    wait_until(s + 610);
    chk("early_done_busy", busy, 0);

    // Reset in the middle of the first Wiener row
    issue_frame(1, s);
    push(EV_NES, s, 0, 1, 1, 0);
    push(EV_WNS, s + 116, 0, 1, 1, 1);
    pulse_noise_ready(s + 20);
    wait_until(s + 120);
    chk("pre_reset_stats_en", wiener_block_stats_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation,
         wiener_block_stats_en, wiener_calc_en, start_data_wiener, start_of_frame_wiener,
         busy, frame_done, block_idx, row_idx}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle_busy", busy, 0);

    // Fresh single-block frame after reset: 1 data slot plus 2 drain slots
    issue_frame(1, s);
    push(EV_NES, s, 0, 1, 1, 0);
    push(EV_WNS, s + 116, 0, 1, 1, 1);
    push(EV_WNS, s + 209, 1, 0, 0, 1);
    push(EV_WNS, s + 302, 2, 0, 0, 1);
    push(EV_DONE, s + 395, 0, 0, 0, 8);
    pulse_noise_ready(s + 20);
    wait_until(s + 410);
    chk("single_done_busy", busy, 0);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event kind=%0d cyc=%0d blk=%0d", e.kind, e.cyc, e.blk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
